// File: rtl/aud_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aud_pkg
//  Description : Shared types and constants for the audio recorder:
//                capture FSM state encoding, sample/address widths and
//                the last usable SRAM word address.
//  Revision    : 1.0 - initial release
// ============================================================================
package aud_pkg;

    localparam int SAMPLE_W = 16;
    localparam int ADDR_W   = 20;
    localparam int CNT_W    = 4;

    localparam logic [ADDR_W-1:0] ADDR_MAX = 20'hFFFFF;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SAMPLE_W - 1);

    // Capture FSM; explicit 3-bit encoding
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_H = 3'd1,
        WAIT_L = 3'd2,
        DELAY  = 3'd3,
        SHIFT  = 3'd4,
        STORE  = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/aud_sipo.sv
`default_nettype none
// ============================================================================
//  Module      : aud_sipo
//  Description : Serial-in parallel-out shift register. MSB arrives first,
//                so each new bit enters at bit 0 and older bits move up.
//                Clear has priority over shift.
//  Revision    : 1.0 - initial release
// ============================================================================
module aud_sipo
    import aud_pkg::*;
(
    input  logic                i_bclk,
    input  logic                i_rst_n,
    input  logic                i_clear,
    input  logic                i_shift_en,
    input  logic                i_sdata,
    output logic [SAMPLE_W-1:0] o_pdata
);

    logic [SAMPLE_W-1:0] r_shift;

    // Shift register: clear discards any partial word, shift appends a bit
    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
        end else if (i_shift_en) begin
            r_shift <= {r_shift[SAMPLE_W-2:0], i_sdata};
        end
    end

    assign o_pdata = r_shift;

endmodule
`default_nettype wire

// File: rtl/aud_recorder.sv
`default_nettype none
// ============================================================================
//  Module      : aud_recorder
//  Description : I2S left-channel recorder. Waits for a clean falling edge
//                of the word clock, skips the I2S delay bit, shifts in 16
//                bits MSB first and presents each sample with an SRAM word
//                address and a one-cycle write strobe. Stops at the top of
//                the address space (sticky full flag).
//  Revision    : 1.0 - initial release
// ============================================================================
module aud_recorder
    import aud_pkg::*;
(
    input  logic                i_bclk,
    input  logic                i_rst_n,
    input  logic                i_adclrck,
    input  logic                i_adcdat,
    input  logic                i_start,
    input  logic                i_pause,
    input  logic                i_stop,
    output logic [SAMPLE_W-1:0] o_data,
    output logic [ADDR_W-1:0]   o_address,
    output logic                o_valid,
    output logic                o_busy,
    output logic                o_full
);

    state_t              r_state;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [SAMPLE_W-1:0] r_data;
    logic [ADDR_W-1:0]   r_address;
    logic                r_valid;
    logic                r_full;

    logic                w_shift_en;
    logic                w_clear;
    logic [SAMPLE_W-1:0] w_sample;

    // A stop aborts the word in flight, so it both blocks the shift and
    // wipes the partial contents; DELAY clears ahead of every new word.
    assign w_shift_en = (r_state == SHIFT) && !i_stop;
    assign w_clear    = (r_state == DELAY) || i_stop;

    aud_sipo u_sipo (
        .i_bclk     (i_bclk),
        .i_rst_n    (i_rst_n),
        .i_clear    (w_clear),
        .i_shift_en (w_shift_en),
        .i_sdata    (i_adcdat),
        .o_pdata    (w_sample)
    );

    // Capture FSM with registered sample, address, strobe and full flag
    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_data    <= '0;
            r_address <= '0;
            r_valid   <= 1'b0;
            r_full    <= 1'b0;
        end else begin
            r_valid <= 1'b0;

            // Advance the address only once the write strobe drops, so the
            // address is stable for the whole strobe; never wrap past the top.
            if (r_valid && (r_address != ADDR_MAX)) begin
                r_address <= r_address + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (i_start && !i_stop) begin
                        r_state   <= WAIT_H;
                        r_address <= '0;
                        r_full    <= 1'b0;
                    end
                end

                // Wait for the right half so capture never starts mid-frame
                WAIT_H: begin
                    if (i_stop) begin
                        r_state <= IDLE;
                    end else if (i_adclrck) begin
                        r_state <= WAIT_L;
                    end
                end

                // Falling word-clock edge: capture unless paused, in which
                // case skip this frame and wait for the next falling edge
                WAIT_L: begin
                    if (i_stop) begin
                        r_state <= IDLE;
                    end else if (!i_adclrck) begin
                        r_state <= i_pause ? WAIT_H : DELAY;
                    end
                end

                // I2S skip bit
                DELAY: begin
                    if (i_stop) begin
                        r_state <= IDLE;
                    end else begin
                        r_bit_cnt <= '0;
                        r_state   <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (i_stop) begin
                        r_bit_cnt <= '0;
                        r_state   <= IDLE;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == CNT_LAST) begin
                            r_state <= STORE;
                        end
                    end
                end

                // A completed word is always written, even alongside a stop
                STORE: begin
                    r_data  <= w_sample;
                    r_valid <= 1'b1;
                    if (r_address == ADDR_MAX) begin
                        r_full  <= 1'b1;
                        r_state <= IDLE;
                    end else if (i_stop) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= WAIT_H;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_data    = r_data;
    assign o_address = r_address;
    assign o_valid   = r_valid;
    assign o_full    = r_full;
    assign o_busy    = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aud_recorder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_aud_recorder
//  Description : Self-checking bench for aud_recorder. A frame generator
//                serializes 64-bclk I2S frames from a queue and pushes the
//                expected write (data, address, strobe cycle) for every
//                frame that should be captured; a monitor pops and compares
//                on each write strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aud_recorder;

    logic        i_bclk = 1'b0;
    logic        i_rst_n;
    logic        i_adclrck;
    logic        i_adcdat;
    logic        i_start;
    logic        i_pause;
    logic        i_stop;
    logic [15:0] o_data;
    logic [19:0] o_address;
    logic        o_valid;
    logic        o_busy;
    logic        o_full;

    aud_recorder dut (
        .i_bclk    (i_bclk),
        .i_rst_n   (i_rst_n),
        .i_adclrck (i_adclrck),
        .i_adcdat  (i_adcdat),
        .i_start   (i_start),
        .i_pause   (i_pause),
        .i_stop    (i_stop),
        .o_data    (o_data),
        .o_address (o_address),
        .o_valid   (o_valid),
        .o_busy    (o_busy),
        .o_full    (o_full)
    );

    always #5 i_bclk = ~i_bclk;

    typedef struct {
        logic [15:0] left;
        logic [15:0] right;
        bit          cap;
        bit          pause;
        int          id;
    } frame_t;

    typedef struct {
        logic [15:0] data;
        logic [19:0] addr;
        int          cyc;
    } exp_t;

    frame_t      fq[$];
    exp_t        sb[$];
    int          checks   = 0;
    int          errors   = 0;
    int          cyc      = 0;
    int          cur_slot = 63;
    int          cur_id   = -1;
    int          next_id  = 0;
    logic [19:0] exp_addr = '0;
    frame_t      cur;

    always @(posedge i_bclk) cyc <= cyc + 1;

    // Frame generator: slot 0 = first edge seeing lrck low, slot 1 = skip
    // bit, slots 2..17 = left MSB..LSB, slots 34..49 = right MSB..LSB.
    // i_pause takes the frame's pause value at slot 10 (mid left word).
    initial begin
        int s;
        s = 0;
        i_adclrck = 1'b1;
        i_adcdat  = 1'b0;
        i_pause   = 1'b0;
        cur = '{left: 16'h0, right: 16'h0, cap: 1'b0, pause: 1'b0, id: -1};
        forever begin
            @(negedge i_bclk);
            if (s == 0) begin
                if (fq.size() > 0) begin
                    cur = fq.pop_front();
                end else begin
                    cur.left  = 16'($urandom);
                    cur.right = 16'($urandom);
                    cur.cap   = 1'b0;
                    cur.pause = i_pause;
                    cur.id    = -1;
                end
                cur_id = cur.id;
                if (cur.cap) begin
                    sb.push_back('{data: cur.left, addr: exp_addr, cyc: cyc + 19});
                    exp_addr = exp_addr + 1'b1;
                end
            end
            i_adclrck = (s >= 32);
            if (s >= 2 && s <= 17)       i_adcdat = cur.left[17 - s];
            else if (s >= 34 && s <= 49) i_adcdat = cur.right[49 - s];
            else                         i_adcdat = (s == 1 || s == 33);
            if (s == 10) i_pause = cur.pause;
            cur_slot = s;
            s = (s + 1) % 64;
        end
    end

    // Scoreboard monitor: every strobe must match the oldest expected write
    always @(negedge i_bclk) begin
        exp_t e;
        if (i_rst_n === 1'b1 && o_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: o_valid=1 addr=%h data=%h, required no write", o_address, o_data);
            end else begin
                e = sb.pop_front();
                checks += 3;
                if (o_data !== e.data) begin
                    errors++;
                    $display("FAIL write_data: got %h, required %h", o_data, e.data);
                end
                if (o_address !== e.addr) begin
                    errors++;
                    $display("FAIL write_addr: got %h, required %h", o_address, e.addr);
                end
                if (cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL write_latency: strobe at cycle %0d, required %0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic push_frame(input logic [15:0] l, input logic [15:0] r,
                              input bit cap, input bit pause, output int id);
        id = next_id;
        next_id++;
        fq.push_back('{left: l, right: r, cap: cap, pause: pause, id: id});
    endtask

    // Returns 1 ns after the edge that samples slot s of frame id
    task automatic wait_edge(input int id, input int s);
        int n = 0;
        @(posedge i_bclk);
        while (!(cur_id == id && cur_slot == s) && n < 5000) begin
            @(posedge i_bclk);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL wait_edge_timeout: frame %0d slot %0d not reached, required within 5000 cycles", id, s);
        end
        #1;
    endtask

    // Returns 1 ns after the slot-s edge once no queued frames remain
    task automatic wait_slot_any(input int s);
        int n = 0;
        @(posedge i_bclk);
        while (!(fq.size() == 0 && cur_slot == s) && n < 5000) begin
            @(posedge i_bclk);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL wait_slot_timeout: slot %0d not reached, required within 5000 cycles", s);
        end
        #1;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(posedge i_bclk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic pulse_stop();
        i_stop = 1'b1;
        @(posedge i_bclk);
        #1;
        i_stop = 1'b0;
    endtask

    // Start during the right half so the next frame is the first captured
    task automatic do_start();
        wait_slot_any(40);
        exp_addr = '0;
        pulse_start();
    endtask

    task automatic do_stop();
        wait_slot_any(40);
        pulse_stop();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((fq.size() != 0 || sb.size() != 0) && n < 3000) begin
            @(negedge i_bclk);
            n++;
        end
        checks++;
        if (fq.size() != 0 || sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d writes outstanding, required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_stop  = 1'b0;
        repeat (3) @(negedge i_bclk);
        checks += 5;
        if (o_busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b, required 0", o_busy); end
        if (o_valid !== 1'b0)    begin errors++; $display("FAIL reset_valid: got %b, required 0", o_valid); end
        if (o_full !== 1'b0)     begin errors++; $display("FAIL reset_full: got %b, required 0", o_full); end
        if (o_data !== 16'h0)    begin errors++; $display("FAIL reset_data: got %h, required 0000", o_data); end
        if (o_address !== 20'h0) begin errors++; $display("FAIL reset_addr: got %h, required 00000", o_address); end
        @(posedge i_bclk);
        #1;
        i_rst_n = 1'b1;
    endtask

    task automatic test_capture();
        int id;
        do_start();
        checks++;
        if (o_busy !== 1'b1) begin errors++; $display("FAIL capture_busy: got %b, required 1", o_busy); end
        push_frame(16'hA5C3, 16'h3C5A, 1'b1, 1'b0, id);
        push_frame(16'h8001, 16'h7FFE, 1'b1, 1'b0, id);
        drain("capture");
        @(negedge i_bclk);
        checks += 3;
        if (o_address !== 20'h2)  begin errors++; $display("FAIL capture_addr_next: got %h, required 00002", o_address); end
        if (o_data !== 16'h8001)  begin errors++; $display("FAIL capture_data_hold: got %h, required 8001", o_data); end
        if (o_valid !== 1'b0)     begin errors++; $display("FAIL capture_strobe_width: got %b, required 0", o_valid); end
        do_stop();
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL capture_stop_busy: got %b, required 0", o_busy); end
    endtask

    task automatic test_right_ignore();
        int id;
        do_start();
        push_frame(16'h0000, 16'hFFFF, 1'b1, 1'b0, id);
        push_frame(16'h0000, 16'hFFFF, 1'b1, 1'b0, id);
        drain("right_ignore");
        checks++;
        if (o_data !== 16'h0000) begin errors++; $display("FAIL right_ignore_data: got %h, required 0000", o_data); end
        do_stop();
    endtask

    task automatic test_pause();
        int id1, id2, id3, id4, id5;
        do_start();
        push_frame(16'h1111, 16'hEEEE, 1'b1, 1'b1, id1);
        push_frame(16'h2222, 16'hDDDD, 1'b0, 1'b1, id2);
        push_frame(16'h3333, 16'hCCCC, 1'b0, 1'b1, id3);
        push_frame(16'h4444, 16'hBBBB, 1'b0, 1'b0, id4);
        push_frame(16'h5555, 16'hAAAA, 1'b1, 1'b0, id5);
        wait_edge(id3, 40);
        checks += 2;
        if (o_address !== 20'h1) begin errors++; $display("FAIL pause_addr_held: got %h, required 00001", o_address); end
        if (o_busy !== 1'b1)     begin errors++; $display("FAIL pause_busy: got %b, required 1", o_busy); end
        drain("pause");
        @(negedge i_bclk);
        checks++;
        if (o_address !== 20'h2) begin errors++; $display("FAIL pause_addr_after: got %h, required 00002", o_address); end
        do_stop();
    endtask

    task automatic test_stop_mid_shift();
        int id1, id2;
        do_start();
        push_frame(16'h7E81, 16'h1234, 1'b1, 1'b0, id1);
        push_frame(16'hBEEF, 16'h4321, 1'b0, 1'b0, id2);
        wait_edge(id2, 8);
        pulse_stop();
        checks += 3;
        if (o_busy !== 1'b0)     begin errors++; $display("FAIL stop_shift_busy: got %b, required 0", o_busy); end
        if (o_address !== 20'h1) begin errors++; $display("FAIL stop_shift_addr: got %h, required 00001", o_address); end
        if (o_data !== 16'h7E81) begin errors++; $display("FAIL stop_shift_data: got %h, required 7E81", o_data); end
        wait_edge(id2, 40);
        drain("stop_shift");
    endtask

    task automatic test_stop_store();
        int id;
        do_start();
        push_frame(16'hC0DE, 16'h0F0F, 1'b1, 1'b0, id);
        wait_edge(id, 17);
        pulse_stop();
        checks += 2;
        if (o_busy !== 1'b0)  begin errors++; $display("FAIL stop_store_busy: got %b, required 0", o_busy); end
        if (o_valid !== 1'b1) begin errors++; $display("FAIL stop_store_valid: got %b, required 1", o_valid); end
        drain("stop_store");
    endtask

    task automatic test_full();
        int id1, id2, id3;
        do_start();
        dut.r_address = 20'hFFFFE;
        exp_addr      = 20'hFFFFE;
        push_frame(16'hAAAA, 16'h1111, 1'b1, 1'b0, id1);
        push_frame(16'h5555, 16'h2222, 1'b1, 1'b0, id2);
        push_frame(16'hFACE, 16'h3333, 1'b0, 1'b0, id3);
        wait_edge(id3, 40);
        drain("full");
        checks += 3;
        if (o_full !== 1'b1)         begin errors++; $display("FAIL full_flag: got %b, required 1", o_full); end
        if (o_busy !== 1'b0)         begin errors++; $display("FAIL full_busy: got %b, required 0", o_busy); end
        if (o_address !== 20'hFFFFF) begin errors++; $display("FAIL full_addr: got %h, required FFFFF", o_address); end
    endtask

    task automatic test_restart();
        int id;
        do_start();
        checks += 3;
        if (o_full !== 1'b0)     begin errors++; $display("FAIL restart_full: got %b, required 0", o_full); end
        if (o_address !== 20'h0) begin errors++; $display("FAIL restart_addr: got %h, required 00000", o_address); end
        if (o_busy !== 1'b1)     begin errors++; $display("FAIL restart_busy: got %b, required 1", o_busy); end
        push_frame(16'h1357, 16'h9BDF, 1'b1, 1'b0, id);
        drain("restart");
        do_stop();
    endtask

    task automatic test_reset_midframe();
        int id1, id2, id3;
        do_start();
        push_frame(16'h9999, 16'h6666, 1'b0, 1'b0, id1);
        wait_edge(id1, 9);
        i_rst_n = 1'b0;
        #1;
        checks += 4;
        if (o_busy !== 1'b0)     begin errors++; $display("FAIL rst_mid_busy: got %b, required 0", o_busy); end
        if (o_valid !== 1'b0)    begin errors++; $display("FAIL rst_mid_valid: got %b, required 0", o_valid); end
        if (o_address !== 20'h0) begin errors++; $display("FAIL rst_mid_addr: got %h, required 00000", o_address); end
        if (o_data !== 16'h0)    begin errors++; $display("FAIL rst_mid_data: got %h, required 0000", o_data); end
        repeat (2) @(posedge i_bclk);
        #1;
        i_rst_n = 1'b1;
        push_frame(16'h2468, 16'h1111, 1'b0, 1'b0, id2);
        push_frame(16'h1359, 16'h2222, 1'b1, 1'b0, id3);
        wait_edge(id2, 5);
        exp_addr = '0;
        pulse_start();
        drain("rst_mid");
        @(negedge i_bclk);
        checks++;
        if (o_address !== 20'h1) begin errors++; $display("FAIL rst_mid_addr_after: got %h, required 00001", o_address); end
        do_stop();
    endtask

    task automatic test_start_stop_same();
        wait_slot_any(40);
        i_start = 1'b1;
        i_stop  = 1'b1;
        @(posedge i_bclk);
        #1;
        i_start = 1'b0;
        i_stop  = 1'b0;
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL start_stop_same_busy: got %b, required 0", o_busy); end
        repeat (64) @(negedge i_bclk);
    endtask

    initial begin
        test_reset();
        test_capture();
        test_right_ignore();
        test_pause();
        test_stop_mid_shift();
        test_stop_store();
        test_full();
        test_restart();
        test_reset_midframe();
        test_start_stop_same();
        drain("final");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
